// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the sequencer: control, instruction memory port, decode handshake and status.
// The sequencer takes the master side; the memory/decode environment takes the slave side.
interface fetch_sequencer_if;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    modport master (
        input  start, imem_word, out_ready, redirect, redirect_pc,
        output imem_addr, out_valid, out_instr, out_pc, halted, fault, fetch_count
    );

    modport slave (
        output start, imem_word, out_ready, redirect, redirect_pc,
        input  imem_addr, out_valid, out_instr, out_pc, halted, fault, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction memory and
// buffers {word, pc} pairs in a small FIFO toward decode, with redirect/flush and halt handling.
//
// state   | meaning
// S_IDLE  | waiting for start (or a redirect)
// S_FETCH | fetching one word per cycle while the FIFO has room
// S_HALT  | no fetches; FIFO drains; left only by redirect
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_LIMIT = 256,
    parameter int unsigned DEPTH     = 2
) (
    input logic               clk,
    input logic               rst_n,
    fetch_sequencer_if.master bus
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic        fault_q;
    logic [15:0] fetch_count_q;

    logic [31:0] fifo_instr [DEPTH];
    logic [31:0] fifo_pc    [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    logic        out_valid_i, pop, fetch_en, push;
    logic        out_of_range, illegal, self_jump, halt_err, halt_ok, misaligned;
    logic        halted_i;
    logic [31:0] jump_target;

    assign out_valid_i  = (count != '0);
    assign pop          = out_valid_i && bus.out_ready;
    assign out_of_range = (pc >= MEM_LIMIT);
    assign illegal      = (bus.imem_word == 32'hFFFF_FFFF);
    assign jump_target  = {pc[31:28], bus.imem_word[25:0], 2'b00};
    assign self_jump    = (bus.imem_word[31:26] == 6'b000010) && (jump_target == pc);
    assign misaligned   = (bus.redirect_pc[1:0] != 2'b00);

    // Range check wins over the word checks: an out-of-range PC never looks at memory data.
    assign push     = fetch_en && !out_of_range && !illegal;
    assign halt_err = fetch_en && (out_of_range || illegal);
    assign halt_ok  = push && self_jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.redirect) begin
            state_nxt = misaligned ? S_HALT : S_FETCH;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_nxt = S_FETCH;
                S_FETCH: if (halt_err || halt_ok) state_nxt = S_HALT;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        halted_i = (state == S_HALT);
        fetch_en = (state == S_FETCH) && ((count < FULL) || pop) && !bus.redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            if (bus.redirect) begin
                pc      <= bus.redirect_pc;
                fault_q <= misaligned;
            end else begin
                if (push)     pc      <= pc + 32'd4;
                if (halt_err) fault_q <= 1'b1;
            end
            if (push && (fetch_count_q != 16'hFFFF)) fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

    // Redirect flushes after letting a same-cycle pop complete; the flush simply empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_word;
            fifo_pc[wr_ptr]    <= pc;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.out_valid   = out_valid_i;
    assign bus.out_instr   = out_valid_i ? fifo_instr[rd_ptr] : 32'h0;
    assign bus.out_pc      = out_valid_i ? fifo_pc[rd_ptr]    : 32'h0;
    assign bus.halted      = halted_i;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a queue-based reference model predicts deliveries into a
// scoreboard; a monitor pops it on every DUT handshake. Status outputs are tracked per cycle.
module tb_fetch_sequencer;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef enum int {M_IDLE, M_RUN, M_HALT} mode_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if ifc();

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_LIMIT(256), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    logic [31:0] mem [64];
    assign ifc.imem_word = (ifc.imem_addr < 32'd256) ? mem[ifc.imem_addr[7:2]] : 32'hFFFF_FFFF;

    int          checks = 0;
    int          errors = 0;
    mode_t       m_st;
    logic [31:0] m_pc;
    logic        m_fault;
    int          m_count;
    ent_t        m_q[$];
    ent_t        sb_q[$];
    logic [31:0] last_pc;

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return 32'hFFFF_FFFF;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic reset_model();
        m_st = M_IDLE; m_pc = 32'h0; m_fault = 1'b0; m_count = 0;
        m_q.delete(); sb_q.delete();
    endtask

    // One clock of the architectural rules: pop, then redirect or fetch.
    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        int          sz  = m_q.size();
        bit          pop = (sz > 0) && rdy;
        logic [31:0] w, tgt;
        if (pop) sb_q.push_back(m_q.pop_front());
        if (rd) begin
            m_q.delete();
            m_pc    = rpc;
            m_fault = (rpc % 4) != 0;
            m_st    = m_fault ? M_HALT : M_RUN;
            return;
        end
        if (m_st == M_IDLE) begin
            if (st) m_st = M_RUN;
        end else if (m_st == M_RUN && (sz < DEPTH || pop)) begin
            w = memw(m_pc);
            if (m_pc >= 256 || w == 32'hFFFF_FFFF) begin
                m_st = M_HALT; m_fault = 1'b1;
            end else begin
                m_q.push_back(ent_t'({w, m_pc}));
                if (m_count < 65535) m_count++;
                tgt = (m_pc & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
                if ((w >> 26) == 32'd2 && tgt == m_pc) m_st = M_HALT;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_status();
        logic [31:0] hp = 32'h0, hi = 32'h0;
        if (m_q.size() > 0) begin hp = m_q[0].pc; hi = m_q[0].instr; end
        chk("imem_addr",   ifc.imem_addr,   m_pc);
        chk("out_valid",   ifc.out_valid,   m_q.size() > 0);
        chk("out_pc",      ifc.out_pc,      hp);
        chk("out_instr",   ifc.out_instr,   hi);
        chk("halted",      ifc.halted,      m_st == M_HALT);
        chk("fault",       ifc.fault,       m_fault);
        chk("fetch_count", ifc.fetch_count, m_count);
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        check_status();
        ifc.start = st; ifc.redirect = rd; ifc.redirect_pc = rpc; ifc.out_ready = rdy;
        #1 model_step(st, rd, rpc, rdy);
    endtask

    task automatic idle_inputs();
        ifc.start = 1'b0; ifc.redirect = 1'b0; ifc.redirect_pc = 32'h0; ifc.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1 reset_model();
        check_status();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_prog();
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b000010) w[31] = 1'b1;
            if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
            mem[i] = (i < 45) ? w : 32'hFFFF_FFFF;
        end
        mem[11] = 32'hAC01_0001;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!(m_st == M_HALT && m_q.size() == 0) && n < budget) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk({name, "_within_budget"}, n < budget, 1'b1);
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ifc.out_valid && ifc.out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_pop: got pc %h instr %h expected nothing", ifc.out_pc, ifc.out_instr);
                end else begin
                    checks--;
                    e = sb_q.pop_front();
                    chk("sb_instr", ifc.out_instr, e.instr);
                    chk("sb_pc",    ifc.out_pc,    e.pc);
                    last_pc = ifc.out_pc;
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] rpc;
        logic        st, rd, rdy;
        int          r;
        idle_inputs();
        reset_model();
        load_prog();

        // Free run from reset until the illegal word at 180
        do_reset();
        chk("rst_fetch_count", ifc.fetch_count, 16'h0);
        chk("rst_halted", ifc.halted, 1'b0);
        chk("rst_out_valid", ifc.out_valid, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_first_valid", ifc.out_valid, 1'b1);
        chk("t1_first_pc", ifc.out_pc, 32'h0);
        run_to_halt("t1", 300);
        chk("t4_last_pc", last_pc, 32'd176);
        chk("t4_fetch_count", ifc.fetch_count, 16'd45);
        chk("t4_halted", ifc.halted, 1'b1);
        chk("t4_fault", ifc.fault, 1'b1);

        // Back-pressure: FIFO fills to two entries and the PC stalls
        do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_addr_stall", ifc.imem_addr, 32'd8);
        chk("t2_head_pc", ifc.out_pc, 32'h0);
        chk("t2_count", ifc.fetch_count, 16'd2);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_delivered_upto", last_pc >= 32'd8, 1'b1);

        // Redirect flushes held entries
        do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h2C, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_pc", ifc.out_pc, 32'h2C);
        chk("t3_instr", ifc.out_instr, 32'hAC01_0001);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Self-jump halts cleanly, redirect resumes
        mem[4] = 32'h0800_0004;
        do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        run_to_halt("t5", 50);
        chk("t5_last_pc", last_pc, 32'h10);
        chk("t5_fault", ifc.fault, 1'b0);
        chk("t5_halted", ifc.halted, 1'b1);
        cycle(1'b0, 1'b1, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_resume_pc", ifc.out_pc, 32'h0);
        run_to_halt("t5b", 50);

        // Asynchronous reset mid-burst, then misaligned redirect
        load_prog();
        do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_pre_valid", ifc.out_valid, 1'b1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("t6_valid", ifc.out_valid, 1'b0);
        chk("t6_pc", ifc.out_pc, 32'h0);
        chk("t6_instr", ifc.out_instr, 32'h0);
        chk("t6_addr", ifc.imem_addr, 32'h0);
        chk("t6_count", ifc.fetch_count, 16'h0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 32'h2E, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_mis_halted", ifc.halted, 1'b1);
        chk("t6_mis_fault", ifc.fault, 1'b1);

        // Randomized traffic with illegal words and self-jumps planted
        for (int i = 0; i < 64; i++) begin
            r = $urandom % 16;
            if (r == 0)      mem[i] = 32'hFFFF_FFFF;
            else if (r == 1) mem[i] = {6'b000010, 26'(i)};
            else             mem[i] = $urandom & 32'hF7FF_FFFE;
        end
        do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom % 8) == 0;
            rdy = ($urandom % 10) < 7;
            rd  = ($urandom % 25) == 0 || (m_st == M_HALT && ($urandom % 4) == 0);
            r   = $urandom % 10;
            if (r < 6)       rpc = ($urandom % 64) << 2;
            else if (r < 8)  rpc = 32'h100 + (($urandom % 8) << 2);
            else if (r == 8) rpc = (($urandom % 64) << 2) | (1 + $urandom % 3);
            else             rpc = 32'hFFFF_FFFC;
            cycle(st, rd, rpc, rdy);
        end
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sb_leftover", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
